// File: rtl/stopwatch_pkg.sv
// ---------------------------------------------------------------------------
// stopwatch_pkg
//   Shared types and constants for the mm:ss stopwatch display block.
//   - sw_state_t : run-control FSM encoding
//   - sw_time_t  : packed BCD time {min_hi, min_lo, sec_hi, sec_lo}
//   - SEG_*      : active-low seven-segment codes {a,b,c,d,e,f,g,dp}
//   - bcd_inc()  : single-digit BCD increment with roll to zero
// ---------------------------------------------------------------------------
package stopwatch_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_RUN   = 2'd1,
      ST_PAUSE = 2'd2
   } sw_state_t;

   typedef struct packed {
      logic [3:0] min_hi;
      logic [3:0] min_lo;
      logic [3:0] sec_hi;
      logic [3:0] sec_lo;
   } sw_time_t;

   // Segment codes, active low, dp (bit 0) off.
   localparam logic [7:0] SEG_0     = 8'h03;
   localparam logic [7:0] SEG_1     = 8'h9F;
   localparam logic [7:0] SEG_2     = 8'h25;
   localparam logic [7:0] SEG_3     = 8'h0D;
   localparam logic [7:0] SEG_4     = 8'h99;
   localparam logic [7:0] SEG_5     = 8'h49;
   localparam logic [7:0] SEG_6     = 8'h41;
   localparam logic [7:0] SEG_7     = 8'h1F;
   localparam logic [7:0] SEG_8     = 8'h01;
   localparam logic [7:0] SEG_9     = 8'h09;
   localparam logic [7:0] SEG_BLANK = 8'hFF;
   // AND mask that lights the dp segment (active low bit 0).
   localparam logic [7:0] DP_MASK   = 8'hFE;

   // Digit upper limits: units digits roll at 9, tens digits at 5.
   localparam logic [3:0] DIG_MAX9  = 4'd9;
   localparam logic [3:0] DIG_MAX5  = 4'd5;

   // Any value at or above the limit rolls to 0, so a digit can never
   // leave its legal range even if it were somehow disturbed.
   function automatic logic [3:0] bcd_inc(input logic [3:0] d,
                                          input logic [3:0] max);
      return (d >= max) ? 4'd0 : d + 4'd1;
   endfunction

endpackage

// File: rtl/bcd2ssd.sv
// ---------------------------------------------------------------------------
// bcd2ssd
//   Combinational 4-bit BCD to 8-bit active-low seven-segment decoder.
//   Ports:
//     bcd  in  4  BCD digit 0..9
//     seg  out 8  {a,b,c,d,e,f,g,dp}, active low, dp always off
//   Non-BCD inputs (10..15) decode to a blank digit.
// ---------------------------------------------------------------------------
module bcd2ssd
   import stopwatch_pkg::*;
(
   input  logic [3:0] bcd,
   output logic [7:0] seg
);

   always_comb begin
      seg = SEG_BLANK;
      case (bcd)
         4'd0:    seg = SEG_0;
         4'd1:    seg = SEG_1;
         4'd2:    seg = SEG_2;
         4'd3:    seg = SEG_3;
         4'd4:    seg = SEG_4;
         4'd5:    seg = SEG_5;
         4'd6:    seg = SEG_6;
         4'd7:    seg = SEG_7;
         4'd8:    seg = SEG_8;
         4'd9:    seg = SEG_9;
         default: seg = SEG_BLANK;
      endcase
   end

endmodule

// File: rtl/stopwatch_disp.sv
// ---------------------------------------------------------------------------
// stopwatch_disp
//   mm:ss stopwatch driving a 4-digit common-anode seven-segment display.
//   Counts rising edges of the frequency divider's slow output under
//   start/pause/clear control. sec_src and scan_sel are sampled as data in
//   the clk domain; nothing here is clocked by them.
//
//   Parameters:
//     TICKS_PER_INC  sec_src rising edges per one-second step (1..255)
//     LEAD_BLANK     1: blank min_hi while it is 0
//   Ports:
//     clk         in   1   clock, posedge
//     rst         in   1   synchronous active-high reset
//     sec_src     in   1   slow square wave (tick source)
//     scan_sel    in   2   digit scan select
//     start_stop  in   1   pulse: toggle run/pause
//     clear       in   1   pulse: stop and zero the time
//     ssd_ctl     out  4   digit enables, active low, [0]=rightmost
//     ssd_seg     out  8   segments {a..g,dp}, active low
//     running     out  1   FSM is in RUN
//     wrap        out  1   pulse on 59:59 -> 00:00
//     bcd         out  16  {min_hi,min_lo,sec_hi,sec_lo}
// ---------------------------------------------------------------------------
module stopwatch_disp
   import stopwatch_pkg::*;
#(
   parameter int TICKS_PER_INC = 1,
   parameter bit LEAD_BLANK    = 1'b1
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        sec_src,
   input  logic [1:0]  scan_sel,
   input  logic        start_stop,
   input  logic        clear,
   output logic [3:0]  ssd_ctl,
   output logic [7:0]  ssd_seg,
   output logic        running,
   output logic        wrap,
   output logic [15:0] bcd
);

   localparam logic [7:0] PRESC_LAST = 8'(TICKS_PER_INC - 1);

   sw_state_t  state;
   sw_time_t   tm;
   logic       sec_src_d;
   logic [7:0] presc;
   logic [1:0] scan_q;

   logic       tick;
   logic       inc;
   logic       c0, c1, c2, c3;

   logic [3:0] dig;
   logic [3:0] ctl_nxt;
   logic       dp_on;
   logic       blank;
   logic [7:0] seg_raw;
   logic [7:0] seg_nxt;

   // ---------------------------------------------------------------------
   // Edge detector. sec_src_d resets high so a sec_src already high out of
   // reset is not taken as a fresh edge.
   // ---------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (rst) sec_src_d <= 1'b1;
      else     sec_src_d <= sec_src;
   end

   assign tick = sec_src & ~sec_src_d;

   // ---------------------------------------------------------------------
   // Prescaler: runs only in RUN, holds in PAUSE, zero in IDLE or on clear.
   // >= keeps an out-of-range count from stalling the increment.
   // ---------------------------------------------------------------------
   assign inc = (state == ST_RUN) && tick && (presc >= PRESC_LAST);

   always_ff @(posedge clk) begin
      if (rst || clear || state == ST_IDLE) begin
         presc <= 8'd0;
      end else if (state == ST_RUN && tick) begin
         if (presc >= PRESC_LAST) presc <= 8'd0;
         else                     presc <= presc + 8'd1;
      end
   end

   // ---------------------------------------------------------------------
   // Run-control FSM. clear beats start_stop; a start_stop arriving with an
   // increment still lets the increment through (counter chain is separate).
   // ---------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (rst || clear) begin
         state   <= ST_IDLE;
         running <= 1'b0;
      end else if (start_stop) begin
         case (state)
            ST_IDLE, ST_PAUSE: begin
               state   <= ST_RUN;
               running <= 1'b1;
            end
            ST_RUN: begin
               state   <= ST_PAUSE;
               running <= 1'b0;
            end
            default: begin
               state   <= ST_IDLE;
               running <= 1'b0;
            end
         endcase
      end
   end

   // ---------------------------------------------------------------------
   // BCD counter chain: sec_lo -> sec_hi -> min_lo -> min_hi.
   // c3 marks the 59:59 -> 00:00 roll.
   // ---------------------------------------------------------------------
   assign c0 = inc && (tm.sec_lo >= DIG_MAX9);
   assign c1 = c0  && (tm.sec_hi >= DIG_MAX5);
   assign c2 = c1  && (tm.min_lo >= DIG_MAX9);
   assign c3 = c2  && (tm.min_hi >= DIG_MAX5);

   always_ff @(posedge clk) begin
      if (rst || clear) begin
         tm <= '0;
      end else if (inc) begin
         tm.sec_lo <= bcd_inc(tm.sec_lo, DIG_MAX9);
         if (c0) tm.sec_hi <= bcd_inc(tm.sec_hi, DIG_MAX5);
         if (c1) tm.min_lo <= bcd_inc(tm.min_lo, DIG_MAX9);
         if (c2) tm.min_hi <= bcd_inc(tm.min_hi, DIG_MAX5);
      end
   end

   // Registered together with the digits, so it is high exactly while
   // bcd first reads 00:00 after the roll.
   always_ff @(posedge clk) begin
      if (rst) wrap <= 1'b0;
      else     wrap <= c3 && !clear;
   end

   assign bcd = tm;

   // ---------------------------------------------------------------------
   // Scan path: scan_sel -> scan_q -> output registers (2 clk latency).
   // The colon is the dp of min_lo.
   // ---------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (rst) scan_q <= 2'd0;
      else     scan_q <= scan_sel;
   end

   always_comb begin
      dig     = tm.sec_lo;
      ctl_nxt = 4'b1110;
      dp_on   = 1'b0;
      blank   = 1'b0;
      case (scan_q)
         2'd1: begin
            dig     = tm.sec_hi;
            ctl_nxt = 4'b1101;
         end
         2'd2: begin
            dig     = tm.min_lo;
            ctl_nxt = 4'b1011;
            dp_on   = 1'b1;
         end
         2'd3: begin
            dig     = tm.min_hi;
            ctl_nxt = 4'b0111;
            blank   = LEAD_BLANK && (tm.min_hi == 4'd0);
         end
         default: begin
            dig     = tm.sec_lo;
            ctl_nxt = 4'b1110;
         end
      endcase
   end

   bcd2ssd u_bcd2ssd (
      .bcd (dig),
      .seg (seg_raw)
   );

   always_comb begin
      seg_nxt = seg_raw;
      if (blank)      seg_nxt = SEG_BLANK;
      else if (dp_on) seg_nxt = seg_raw & DP_MASK;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         ssd_ctl <= 4'b1111;
         ssd_seg <= SEG_BLANK;
      end else begin
         ssd_ctl <= ctl_nxt;
         ssd_seg <= seg_nxt;
      end
   end

endmodule
